// File: rtl/pcs_synchronization.sv
// -----------------------------------------------------------------------------
// pcs_synchronization
// 1000BASE-X PCS receive synchronization state machine. Each code-group on
// PUDI is qualified (validity, comma, running disparity). The machine then
// acquires, holds or loses code-group alignment.
//
// Ports
//   GTX_CLK        in   1   one code-group per rising edge
//   mr_main_reset  in   1   synchronous active-high reset
//   PUDI           in  10   code-group from the PMA, bit 9 = 'a' ... bit 0 = 'j'
//   signal_detect  in   1   PMA reports a signal present
//   sync_status    out  1   1 = alignment OK, 0 = FAIL
//   rx_even        out  1   current SUDI occupies an even position
//   SUDI           out 10   PUDI registered once, aligned with the flags
//   cg_invalid     out  1   current SUDI judged invalid
//   cg_comma       out  1   current SUDI contains a comma
//   rx_rd          out  1   running disparity after current SUDI (1 = RD+)
// -----------------------------------------------------------------------------
module pcs_synchronization #(
    parameter int GOOD_CGS_TARGET = 3,
    parameter bit CHECK_RD        = 1'b1
) (
    input  logic       GTX_CLK,
    input  logic       mr_main_reset,
    input  logic [9:0] PUDI,
    input  logic       signal_detect,
    output logic       sync_status,
    output logic       rx_even,
    output logic [9:0] SUDI,
    output logic       cg_invalid,
    output logic       cg_comma,
    output logic       rx_rd
);

    typedef enum logic [3:0] {
        LOSS_OF_SYNC,
        COMMA_DETECT_1, ACQUIRE_SYNC_1,
        COMMA_DETECT_2, ACQUIRE_SYNC_2,
        COMMA_DETECT_3,
        SYNC_ACQUIRED_1,
        SYNC_ACQUIRED_2, SYNC_ACQUIRED_2A,
        SYNC_ACQUIRED_3, SYNC_ACQUIRED_3A,
        SYNC_ACQUIRED_4, SYNC_ACQUIRED_4A
    } state_t;

    localparam logic [1:0] CGS_TARGET = 2'(GOOD_CGS_TARGET);

    state_t     state_reg, state_next;
    logic [1:0] good_cgs_reg, good_cgs_next;
    logic       rx_even_reg, rx_even_next;
    logic       rx_rd_reg, rx_rd_next;
    logic [9:0] sudi_reg;
    logic       cg_invalid_reg, cg_comma_reg;

    function automatic logic [3:0] count_ones(input logic [9:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 10; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // ---------------------------------------------------------------------
    // Code-group qualification of the word being sampled this edge
    // ---------------------------------------------------------------------
    logic [3:0] ones_hi, ones_lo, ones_all;
    logic       is_comma, is_valid, is_data, rd_ok, cgbad, in_sync;

    assign ones_hi  = count_ones({4'b0000, PUDI[9:4]});
    assign ones_lo  = count_ones({6'b000000, PUDI[3:0]});
    assign ones_all = ones_hi + ones_lo;

    assign is_comma = (PUDI[9:3] == 7'b0011111) || (PUDI[9:3] == 7'b1100000);

    // Six ones is disparity +2 (legal only from RD-), four ones is -2 (legal
    // only from RD+).
    assign rd_ok = !CHECK_RD ||
                   ((ones_all == 4'd6) ? !rx_rd_reg :
                    (ones_all == 4'd4) ?  rx_rd_reg : 1'b1);

    assign is_valid = (ones_hi >= 4'd2) && (ones_hi <= 4'd4) &&
                      (ones_lo >= 4'd1) && (ones_lo <= 4'd3) &&
                      (ones_all >= 4'd4) && (ones_all <= 4'd6) && rd_ok;

    assign is_data = is_valid && (PUDI[9:4] != 6'b001111) && (PUDI[9:4] != 6'b110000);

    // A comma landing in an odd slot means alignment has slipped.
    assign cgbad = !is_valid || (is_comma && rx_even_reg);

    assign in_sync = (state_reg inside {SYNC_ACQUIRED_1,
                                        SYNC_ACQUIRED_2, SYNC_ACQUIRED_2A,
                                        SYNC_ACQUIRED_3, SYNC_ACQUIRED_3A,
                                        SYNC_ACQUIRED_4, SYNC_ACQUIRED_4A});

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        good_cgs_next = good_cgs_reg;
        case (state_reg)
            LOSS_OF_SYNC:   if (is_comma) state_next = COMMA_DETECT_1;
            COMMA_DETECT_1: state_next = is_data ? ACQUIRE_SYNC_1  : LOSS_OF_SYNC;
            COMMA_DETECT_2: state_next = is_data ? ACQUIRE_SYNC_2  : LOSS_OF_SYNC;
            COMMA_DETECT_3: state_next = is_data ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
            ACQUIRE_SYNC_1: begin
                if (cgbad)                          state_next = LOSS_OF_SYNC;
                else if (is_comma && !rx_even_reg)  state_next = COMMA_DETECT_2;
            end
            ACQUIRE_SYNC_2: begin
                if (cgbad)                          state_next = LOSS_OF_SYNC;
                else if (is_comma && !rx_even_reg)  state_next = COMMA_DETECT_3;
            end
            SYNC_ACQUIRED_1: begin
                if (cgbad) begin
                    state_next    = SYNC_ACQUIRED_2;
                    good_cgs_next = 2'd0;
                end
            end
            SYNC_ACQUIRED_2, SYNC_ACQUIRED_3, SYNC_ACQUIRED_4: begin
                if (cgbad) begin
                    good_cgs_next = 2'd0;
                    state_next = (state_reg == SYNC_ACQUIRED_2) ? SYNC_ACQUIRED_3 :
                                 (state_reg == SYNC_ACQUIRED_3) ? SYNC_ACQUIRED_4 :
                                                                  LOSS_OF_SYNC;
                end else begin
                    good_cgs_next = 2'd1;
                    state_next = (state_reg == SYNC_ACQUIRED_2) ? SYNC_ACQUIRED_2A :
                                 (state_reg == SYNC_ACQUIRED_3) ? SYNC_ACQUIRED_3A :
                                                                  SYNC_ACQUIRED_4A;
                end
            end
            SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4A: begin
                if (cgbad) begin
                    good_cgs_next = 2'd0;
                    state_next = (state_reg == SYNC_ACQUIRED_2A) ? SYNC_ACQUIRED_3 :
                                 (state_reg == SYNC_ACQUIRED_3A) ? SYNC_ACQUIRED_4 :
                                                                   LOSS_OF_SYNC;
                end else if (good_cgs_reg == CGS_TARGET) begin
                    good_cgs_next = 2'd0;
                    state_next = (state_reg == SYNC_ACQUIRED_2A) ? SYNC_ACQUIRED_1 :
                                 (state_reg == SYNC_ACQUIRED_3A) ? SYNC_ACQUIRED_2 :
                                                                   SYNC_ACQUIRED_3;
                end else begin
                    good_cgs_next = (good_cgs_reg == 2'd3) ? 2'd3 : good_cgs_reg + 2'd1;
                end
            end
            default: state_next = LOSS_OF_SYNC;
        endcase

        // Losing the signal overrides every other transition.
        if (!signal_detect) begin
            state_next    = LOSS_OF_SYNC;
            good_cgs_next = 2'd0;
        end
    end

    always_comb begin
        rx_even_next = ~rx_even_reg;
        if (state_next inside {COMMA_DETECT_1, COMMA_DETECT_2, COMMA_DETECT_3}) begin
            rx_even_next = 1'b1;
        end else if (in_sync && is_comma) begin
            rx_even_next = 1'b1;
        end
    end

    // Disparity flips on every unbalanced code-group, valid or not.
    assign rx_rd_next = (ones_all != 4'd5) ? ~rx_rd_reg : rx_rd_reg;

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge GTX_CLK) begin
        if (mr_main_reset) begin
            state_reg      <= LOSS_OF_SYNC;
            good_cgs_reg   <= 2'd0;
            rx_even_reg    <= 1'b0;
            rx_rd_reg      <= 1'b0;
            sudi_reg       <= 10'd0;
            cg_invalid_reg <= 1'b0;
            cg_comma_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            good_cgs_reg   <= good_cgs_next;
            rx_even_reg    <= rx_even_next;
            rx_rd_reg      <= rx_rd_next;
            sudi_reg       <= PUDI;
            cg_invalid_reg <= !is_valid;
            cg_comma_reg   <= is_comma;
        end
    end

    assign sync_status = in_sync;
    assign rx_even     = rx_even_reg;
    assign SUDI        = sudi_reg;
    assign cg_invalid  = cg_invalid_reg;
    assign cg_comma    = cg_comma_reg;
    assign rx_rd       = rx_rd_reg;

endmodule

// File: tb/tb_pcs_synchronization.sv
// -----------------------------------------------------------------------------
// tb_pcs_synchronization
// Directed table of code-groups with hand-computed expected flags, plus a
// hand-written sequence with signal_detect held low. A second instance with
// disparity checking disabled shares the stimulus; only its cg_invalid is
// compared.
// -----------------------------------------------------------------------------
module tb_pcs_synchronization;

    localparam logic [9:0] K_N = 10'b0011111010;   // K28.5 RD-
    localparam logic [9:0] K_P = 10'b1100000101;   // K28.5 RD+
    localparam logic [9:0] D_P = 10'b1001000101;   // D16.2 RD+
    localparam logic [9:0] BAD = 10'b1111111111;

    logic       clk = 1'b0;
    logic       mr_main_reset = 1'b1;
    logic [9:0] PUDI = 10'd0;
    logic       signal_detect = 1'b1;

    logic       sync_status, rx_even, cg_invalid, cg_comma, rx_rd;
    logic [9:0] SUDI;
    logic       n_sync_status, n_rx_even, n_cg_invalid, n_cg_comma, n_rx_rd;
    logic [9:0] n_SUDI;

    int checks = 0;
    int errors = 0;

    always #4 clk = ~clk;

    pcs_synchronization #(.GOOD_CGS_TARGET(3), .CHECK_RD(1'b1)) dut (
        .GTX_CLK(clk), .mr_main_reset(mr_main_reset), .PUDI(PUDI),
        .signal_detect(signal_detect), .sync_status(sync_status),
        .rx_even(rx_even), .SUDI(SUDI), .cg_invalid(cg_invalid),
        .cg_comma(cg_comma), .rx_rd(rx_rd)
    );

    pcs_synchronization #(.GOOD_CGS_TARGET(3), .CHECK_RD(1'b0)) dut_nochk (
        .GTX_CLK(clk), .mr_main_reset(mr_main_reset), .PUDI(PUDI),
        .signal_detect(signal_detect), .sync_status(n_sync_status),
        .rx_even(n_rx_even), .SUDI(n_SUDI), .cg_invalid(n_cg_invalid),
        .cg_comma(n_cg_comma), .rx_rd(n_rx_rd)
    );

    typedef struct {
        logic       rst;
        logic       sd;
        logic [9:0] pudi;
        logic       sync;
        logic       even;
        logic       inv;
        logic       comma;
        logic       rd;
        logic       inv_aux;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic s, input logic [9:0] p,
                       input logic sy, input logic ev, input logic iv,
                       input logic cm, input logic rd, input logic ia);
        vec_t v;
        v.rst = r; v.sd = s; v.pudi = p; v.sync = sy; v.even = ev;
        v.inv = iv; v.comma = cm; v.rd = rd; v.inv_aux = ia;
        vq.push_back(v);
    endtask

    // From LOSS_OF_SYNC with rx_even=0, RD-: six /I2/ code-groups reach SYNC_ACQUIRED_1.
    task automatic add_acquire();
        add(0,1,K_N, 0,1,0,1,1, 0);   // COMMA_DETECT_1
        add(0,1,D_P, 0,0,0,0,0, 0);   // ACQUIRE_SYNC_1
        add(0,1,K_N, 0,1,0,1,1, 0);   // COMMA_DETECT_2
        add(0,1,D_P, 0,0,0,0,0, 0);   // ACQUIRE_SYNC_2
        add(0,1,K_N, 0,1,0,1,1, 0);   // COMMA_DETECT_3
        add(0,1,D_P, 1,0,0,0,0, 0);   // SYNC_ACQUIRED_1
    endtask

    task automatic check(input string name, input int idx,
                         input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic s, input logic [9:0] p);
        mr_main_reset = r;
        signal_detect = s;
        PUDI          = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_even, exp_rd;
        logic [9:0] exp_sudi;

        // reset
        add(1,1,K_N, 0,0,0,0,0, 0);
        add(1,1,D_P, 0,0,0,0,0, 0);
        // acquire, stay synced
        add_acquire();
        add(0,1,K_N, 1,1,0,1,1, 0);
        add(0,1,D_P, 1,0,0,0,0, 0);
        // loss: SA1 -> SA2 -> SA3 -> SA4 -> LOSS
        add(0,1,BAD, 1,1,1,0,1, 1);
        add(0,1,BAD, 1,0,1,0,0, 1);
        add(0,1,BAD, 1,1,1,0,1, 1);
        add(0,1,BAD, 0,0,1,0,0, 1);
        // reacquire, then recovery: 1 invalid + 4 valid back to SA1
        add_acquire();
        add(0,1,BAD, 1,1,1,0,1, 1);   // SA2
        add(0,1,D_P, 1,0,0,0,0, 0);   // SA2A g=1
        add(0,1,K_N, 1,1,0,1,1, 0);   // g=2
        add(0,1,D_P, 1,0,0,0,0, 0);   // g=3
        add(0,1,K_N, 1,1,0,1,1, 0);   // SA1
        // misaligned comma (rx_even=1) -> SA2, then three bad reach LOSS
        add(0,1,K_P, 1,1,0,1,0, 0);
        add(0,1,BAD, 1,0,1,0,1, 1);   // SA3
        add(0,1,BAD, 1,1,1,0,0, 1);   // SA4
        add(0,1,BAD, 0,0,1,0,1, 1);   // LOSS
        // disparity error: K28.5- twice from reset
        add(1,1,D_P, 0,0,0,0,0, 0);
        add(0,1,K_N, 0,1,0,1,1, 0);
        add(0,1,K_N, 0,0,1,1,0, 0);   // invalid only when RD is checked
        // reset in the middle of acquisition
        add(0,1,K_N, 0,1,0,1,1, 0);
        add(0,1,D_P, 0,0,0,0,0, 0);
        add(0,1,K_N, 0,1,0,1,1, 0);
        add(1,1,D_P, 0,0,0,0,0, 0);
        // signal drop while synced overrides SA1 -> SA2
        add_acquire();
        add(0,0,BAD, 0,1,1,0,1, 1);

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i].rst, vq[i].sd, vq[i].pudi);
            exp_sudi = vq[i].rst ? 10'd0 : vq[i].pudi;
            check("sync_status",  i, {9'd0, sync_status},  {9'd0, vq[i].sync});
            check("rx_even",      i, {9'd0, rx_even},      {9'd0, vq[i].even});
            check("cg_invalid",   i, {9'd0, cg_invalid},   {9'd0, vq[i].inv});
            check("cg_comma",     i, {9'd0, cg_comma},     {9'd0, vq[i].comma});
            check("rx_rd",        i, {9'd0, rx_rd},        {9'd0, vq[i].rd});
            check("SUDI",         i, SUDI,                 exp_sudi);
            check("nochk_invalid",i, {9'd0, n_cg_invalid}, {9'd0, vq[i].inv_aux});
            $display("step %0d rst=%0b sd=%0b pudi=%b sync=%0b even=%0b inv=%0b comma=%0b rd=%0b",
                     i, vq[i].rst, vq[i].sd, vq[i].pudi, sync_status, rx_even,
                     cg_invalid, cg_comma, rx_rd);
        end

        // signal_detect held low: /I2/ stream never synchronizes, rx_even keeps toggling
        exp_even = 1'b1;
        exp_rd   = 1'b1;
        for (int j = 0; j < 8; j++) begin
            apply(1'b0, 1'b0, (j % 2 == 0) ? D_P : K_N);
            exp_even = ~exp_even;
            exp_rd   = ~exp_rd;
            check("nosig_sync",    100 + j, {9'd0, sync_status}, 10'd0);
            check("nosig_rx_even", 100 + j, {9'd0, rx_even},     {9'd0, exp_even});
            check("nosig_rx_rd",   100 + j, {9'd0, rx_rd},       {9'd0, exp_rd});
            check("nosig_invalid", 100 + j, {9'd0, cg_invalid},  10'd0);
            $display("nosig %0d sync=%0b even=%0b rd=%0b", j, sync_status, rx_even, rx_rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcs_synchronization.md
Name: pcs_synchronization

Overview:
- PCS receive synchronization state machine for 1000BASE-X (IEEE 802.3 Clause 36, Fig. 36-9).
- Consumes the 10-bit code-group stream PUDI. On the PMA loopback path, this is the same stream the transmit block drives on PUDR.
- Qualifies each code-group (validity, comma, running disparity) and acquires or loses code-group alignment.
- Drives sync_status, rx_even and the registered SUDI to the downstream receive state machine.

Parameters:
- GOOD_CGS_TARGET, 3: consecutive good code-groups needed to climb back one step (SYNC_ACQUIRED_nA).
- CHECK_RD, 1: 1 = running-disparity violations count as invalid code-groups; 0 = disparity not checked.

Ports:
- GTX_CLK  input  1  receive/transmit clock, one code-group per rising edge
- mr_main_reset  input  1  synchronous active-high reset
- PUDI  input  10  code-group from PMA; bit 9 = 'a' (first bit), bit 0 = 'j'; layout abcdei fghj
- signal_detect  input  1  PMA signal present
- sync_status  output  1  1 = OK, 0 = FAIL
- rx_even  output  1  1 = current SUDI is in an even position
- SUDI  output  10  PUDI registered once, aligned with sync_status/rx_even
- cg_invalid  output  1  registered: current SUDI judged invalid
- cg_comma  output  1  registered: current SUDI contains a comma
- rx_rd  output  1  running disparity after current SUDI (0 = negative, 1 = positive)

Behaviour:
- Reset (on any GTX_CLK edge with mr_main_reset=1, including mid-acquisition):
  - state = LOSS_OF_SYNC; sync_status = 0; rx_even = 0; SUDI = 0; cg_invalid = 0; cg_comma = 0; rx_rd = 0 (RD-); good_cgs = 0.
- Latency: every output reflects the PUDI sampled at the same edge, i.e. one cycle after presentation.
- Comma: PUDI[9:3] equals 0011111 or 1100000.
- Valid code-group:
  - ones count of abcdei (PUDI[9:4]) in {2,3,4};
  - ones count of fghj (PUDI[3:0]) in {1,2,3};
  - total disparity in {-2,0,+2};
  - with CHECK_RD=1: +2 allowed only when RD-, and -2 allowed only when RD+.
- RD update: flips on every code-group with nonzero disparity, valid or not; unchanged on disparity 0.
- D (data): valid, and abcdei not in {001111, 110000}.
- cgbad = invalid OR (comma AND rx_even=1), where rx_even is the value held before the edge. cggood = NOT cgbad.
- signal_detect=0 in any state: next state is LOSS_OF_SYNC. This has priority over all other transitions.
- LOSS_OF_SYNC:
  - sync_status = 0; rx_even toggles every cycle.
  - comma → COMMA_DETECT_1; else stay.
- COMMA_DETECT_n (n = 1, 2, 3):
  - Entering sets rx_even = 1.
  - D → ACQUIRE_SYNC_n (n=1,2) or SYNC_ACQUIRED_1 (n=3); otherwise → LOSS_OF_SYNC.
- ACQUIRE_SYNC_n (n = 1, 2):
  - rx_even toggles.
  - cgbad → LOSS_OF_SYNC.
  - comma with rx_even=0 → COMMA_DETECT_{n+1}.
  - Otherwise stay.
- SYNC_ACQUIRED_1:
  - sync_status = 1; rx_even toggles.
  - cggood → stay; cgbad → SYNC_ACQUIRED_2.
- SYNC_ACQUIRED_k (k = 2, 3, 4):
  - Entering clears good_cgs.
  - cggood → kA with good_cgs = 1.
  - cgbad → SYNC_ACQUIRED_{k+1}; from k=4 → LOSS_OF_SYNC.
- SYNC_ACQUIRED_kA:
  - cggood increments good_cgs.
  - good_cgs == GOOD_CGS_TARGET with cggood → SYNC_ACQUIRED_{k-1} (2A returns to 1).
  - cgbad → SYNC_ACQUIRED_{k+1}; from 4A → LOSS_OF_SYNC.
- sync_status stays 1 in every SYNC_ACQUIRED* state.
- good_cgs is 2 bits wide and saturates; it never wraps.
- rx_even toggles in every SYNC_ACQUIRED* state. A comma while synced forces rx_even = 1 for that cycle.

Test Plan:
- Acquire: start from reset with signal_detect=1. Drive /I2/ repeated, i.e. K28.5- (0011111010) then D16.2+ (1001000101).
  - sync_status = 1 after the 6th code-group edge.
  - rx_even = 1 on every K28.5.
  - rx_rd alternates 1, 0.
  - cg_invalid never set.
- Loss: once synced, drive 4 × 1111111111.
  - cg_invalid = 1 each cycle.
  - Path SYNC_ACQUIRED_1 → 2 → 3 → 4 → LOSS_OF_SYNC.
  - sync_status = 0 after the 4th.
- Recovery: once synced, drive 1 invalid then 4 valid /I2/ code-groups.
  - Returns to SYNC_ACQUIRED_1.
  - sync_status stays 1 throughout.
- Misaligned comma: once synced, insert one K28.5 where rx_even=1.
  - Treated as cgbad → SYNC_ACQUIRED_2; sync_status stays 1.
- RD error: with CHECK_RD=1, send K28.5- twice in a row.
  - Second code-group gives cg_invalid = 1 and rx_rd = 0.
  - With CHECK_RD=0 the same stimulus gives cg_invalid = 0.
- Reset/signal: assert mr_main_reset after the 3rd code-group of acquisition; all outputs are 0 next edge. Separately, drop signal_detect while synced; sync_status = 0 next edge.
